// File: rtl/program_load_arbiter.sv
// rtl/program_load_arbiter.sv - shares the program memory port between the CPU and the UART loader
// Optional checksum accumulator enabled by defining LOAD_CHECKSUM_EN.
module program_load_arbiter #(
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_REGISTERS     = 16,
    parameter int UART_DATA_LENGTH     = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   p_programm_i,
    input  logic [UART_DATA_LENGTH-1:0]            rx_data_i,
    input  logic                                   rx_valid_i,
    input  logic                                   cpu_req_i,
    input  logic                                   cpu_we_i,
    input  logic [MEMORY_ADDRESS_WIDTH-1:0]        cpu_addr_i,
    input  logic [REGISTER_WIDTH-1:0]              cpu_wdata_i,
    output logic                                   cpu_gnt_o,
    output logic [REGISTER_WIDTH-1:0]              cpu_rdata_o,
    output logic                                   cpu_halt_o,
    output logic                                   cpu_restart_o,
    output logic                                   mem_we_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0]        mem_addr_o,
    output logic [REGISTER_WIDTH-1:0]              mem_wdata_o,
    input  logic [REGISTER_WIDTH-1:0]              mem_rdata_i,
    output logic                                   load_busy_o,
    output logic [$clog2(MEMORY_REGISTERS+1)-1:0]  load_count_o,
    output logic                                   load_err_o,
    output logic [REGISTER_WIDTH-1:0]              checksum_o
);

    localparam int COUNT_WIDTH = $clog2(MEMORY_REGISTERS + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MEMORY_REGISTERS);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD,
        ST_RELEASE
    } state_t;

    state_t                        state;
    logic                          pend_valid;
    logic [UART_DATA_LENGTH-1:0]   pend_data;
    logic                          load_write;

    // A byte arriving while one is pending replaces it, so the older one is never written.
    assign load_write  = rst_n_i && (state == ST_LOAD) && pend_valid && !rx_valid_i;
    assign cpu_rdata_o = mem_rdata_i;

    always_comb begin
        cpu_gnt_o   = 1'b0;
        mem_we_o    = load_write;
        mem_addr_o  = pend_data[UART_DATA_LENGTH-1:REGISTER_WIDTH];
        mem_wdata_o = pend_data[REGISTER_WIDTH-1:0];
        if (state == ST_RUN) begin
            cpu_gnt_o   = cpu_req_i;
            mem_we_o    = cpu_req_i && cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= ST_RUN;
            cpu_halt_o    <= 1'b0;
            cpu_restart_o <= 1'b0;
            load_busy_o   <= 1'b0;
            load_err_o    <= 1'b0;
            load_count_o  <= '0;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
        end else begin
            cpu_restart_o <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (p_programm_i) begin
                        state        <= ST_DRAIN;
                        cpu_halt_o   <= 1'b1;
                        load_busy_o  <= 1'b1;
                        load_count_o <= '0;
                        load_err_o   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_LOAD;
                    pend_valid <= 1'b0;
                end
                ST_LOAD: begin
                    if (rx_valid_i) begin
                        pend_data  <= rx_data_i;
                        pend_valid <= 1'b1;
                        if (pend_valid) begin
                            load_err_o <= 1'b1;
                        end
                    end else if (pend_valid) begin
                        pend_valid <= 1'b0;
                        if (load_count_o != COUNT_MAX) begin
                            load_count_o <= load_count_o + 1'b1;
                        end
                    end else if (!p_programm_i) begin
                        state         <= ST_RELEASE;
                        cpu_restart_o <= 1'b1;
                        load_busy_o   <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state      <= ST_RUN;
                    cpu_halt_o <= 1'b0;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            checksum_o <= '0;
        end else if ((state == ST_RUN) && p_programm_i) begin
            checksum_o <= '0;
        end else if (load_write) begin
            checksum_o <= checksum_o + mem_wdata_o;
        end
    end
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_program_load_arbiter.sv
// tb/tb_program_load_arbiter.sv - randomized directed bench for program_load_arbiter
module tb_program_load_arbiter;

    logic       clk = 1'b0;
    logic       rst_n, p_prog, rx_valid, cpu_req, cpu_we;
    logic [7:0] rx_data;
    logic [3:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata, checksum;
    logic       cpu_gnt, cpu_halt, cpu_restart, mem_we, load_busy, load_err;
    logic [4:0] load_count;

    logic [3:0] mem [16];
    logic [3:0] exp_mem [16];
    logic       mem_clear;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    program_load_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n), .p_programm_i(p_prog),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rdata_o(cpu_rdata), .cpu_halt_o(cpu_halt),
        .cpu_restart_o(cpu_restart), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .load_busy_o(load_busy),
        .load_count_o(load_count), .load_err_o(load_err), .checksum_o(checksum)
    );

    // Memory array the block owns the port of.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s mem[%0d]", tag, i), mem[i] === exp_mem[i], 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    // Full load session; expectations come from the byte list and its arrival spacing.
    task automatic load_session(input string name, input logic [7:0] bytes[$], input int gaps[$],
                                input bit fall_with_last);
        int         n, nw, exp_cnt;
        bit         ovr;
        logic [3:0] cks, exp_ck, a, d;
        n = bytes.size();
        a = 4'($urandom_range(0, 15));
        d = 4'($urandom);
        p_prog = 1; cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d; #1;
        check({name, " entry gnt"}, cpu_gnt === 1'b1, 32'(cpu_gnt), 32'(1));
        check({name, " entry we"}, mem_we === 1'b1, 32'(mem_we), 32'(1));
        exp_mem[a] = d;
        tick();
        check({name, " drain halt"}, cpu_halt === 1'b1, 32'(cpu_halt), 32'(1));
        check({name, " drain busy"}, load_busy === 1'b1, 32'(load_busy), 32'(1));
        check({name, " drain gnt"}, cpu_gnt === 1'b0, 32'(cpu_gnt), 32'(0));
        check({name, " drain we"}, mem_we === 1'b0, 32'(mem_we), 32'(0));
        check({name, " drain count"}, load_count === 5'd0, 32'(load_count), 32'(0));
        check({name, " drain err"}, load_err === 1'b0, 32'(load_err), 32'(0));
        cpu_req = 0; cpu_we = 0;
        tick();
        check({name, " load halt"}, cpu_halt === 1'b1, 32'(cpu_halt), 32'(1));
        nw = 0; cks = 0; ovr = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gaps[i] == 0) ovr = 1;
            if (i == n - 1 || gaps[i+1] != 0) begin
                exp_mem[bytes[i][7:4]] = bytes[i][3:0];
                nw++;
                cks = cks + bytes[i][3:0];
            end
        end
        exp_cnt = (nw > 16) ? 16 : nw;
`ifdef LOAD_CHECKSUM_EN
        exp_ck = cks;
`else
        exp_ck = 4'h0;
`endif
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                repeat (gaps[0]) tick();
            end else if (gaps[i] > 0) begin
                rx_valid = 0; #1;
                check({name, " write we"}, mem_we === 1'b1, 32'(mem_we), 32'(1));
                check({name, " write addr"}, mem_addr === bytes[i-1][7:4], 32'(mem_addr), 32'(bytes[i-1][7:4]));
                check({name, " write data"}, mem_wdata === bytes[i-1][3:0], 32'(mem_wdata), 32'(bytes[i-1][3:0]));
                tick();
                repeat (gaps[i] - 1) tick();
            end
            rx_valid = 1; rx_data = bytes[i];
            if (fall_with_last && i == n - 1) p_prog = 0;
            #1;
            check({name, " arrive we"}, mem_we === 1'b0, 32'(mem_we), 32'(0));
            tick();
        end
        rx_valid = 0; #1;
        check({name, " last we"}, mem_we === 1'b1, 32'(mem_we), 32'(1));
        check({name, " last addr"}, mem_addr === bytes[n-1][7:4], 32'(mem_addr), 32'(bytes[n-1][7:4]));
        check({name, " last data"}, mem_wdata === bytes[n-1][3:0], 32'(mem_wdata), 32'(bytes[n-1][3:0]));
        tick();
        check({name, " still load busy"}, load_busy === 1'b1, 32'(load_busy), 32'(1));
        check({name, " no early restart"}, cpu_restart === 1'b0, 32'(cpu_restart), 32'(0));
        check({name, " count"}, load_count === 5'(exp_cnt), 32'(load_count), 32'(exp_cnt));
        check({name, " err"}, load_err === ovr, 32'(load_err), 32'(ovr));
        check({name, " checksum"}, checksum === exp_ck, 32'(checksum), 32'(exp_ck));
        p_prog = 0;
        tick();
        check({name, " release restart"}, cpu_restart === 1'b1, 32'(cpu_restart), 32'(1));
        check({name, " release halt"}, cpu_halt === 1'b1, 32'(cpu_halt), 32'(1));
        check({name, " release busy"}, load_busy === 1'b0, 32'(load_busy), 32'(0));
        tick();
        check({name, " run restart"}, cpu_restart === 1'b0, 32'(cpu_restart), 32'(0));
        check({name, " run halt"}, cpu_halt === 1'b0, 32'(cpu_halt), 32'(0));
        check({name, " run count hold"}, load_count === 5'(exp_cnt), 32'(load_count), 32'(exp_cnt));
        check({name, " run err hold"}, load_err === ovr, 32'(load_err), 32'(ovr));
        check({name, " run checksum hold"}, checksum === exp_ck, 32'(checksum), 32'(exp_ck));
        a = 4'($urandom_range(0, 15));
        cpu_req = 1; cpu_we = 0; cpu_addr = a; #1;
        check({name, " run read gnt"}, cpu_gnt === 1'b1, 32'(cpu_gnt), 32'(1));
        check({name, " run read data"}, cpu_rdata === exp_mem[a], 32'(cpu_rdata), 32'(exp_mem[a]));
        cpu_req = 0;
        check_mem(name);
    endtask

    initial begin
        logic [7:0] bq[$];
        int         gq[$];
        logic [3:0] a, d;
        rst_n = 0; mem_clear = 1; p_prog = 0; rx_valid = 0; rx_data = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 4'h0;
        tick(); tick();
        check("reset halt", cpu_halt === 1'b0, 32'(cpu_halt), 32'(0));
        check("reset restart", cpu_restart === 1'b0, 32'(cpu_restart), 32'(0));
        check("reset busy", load_busy === 1'b0, 32'(load_busy), 32'(0));
        check("reset err", load_err === 1'b0, 32'(load_err), 32'(0));
        check("reset count", load_count === 5'd0, 32'(load_count), 32'(0));
        check("reset checksum", checksum === 4'h0, 32'(checksum), 32'(0));
        check("reset we", mem_we === 1'b0, 32'(mem_we), 32'(0));
        rst_n = 1; mem_clear = 0;
        tick();

        // CPU traffic in run mode; UART strobes here must be ignored.
        for (int k = 0; k < 5; k++) begin
            a = (k == 0) ? 4'h3 : 4'($urandom_range(0, 15));
            d = (k == 0) ? 4'hA : 4'($urandom);
            cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
            rx_valid = 1; rx_data = 8'($urandom); #1;
            check("run write gnt", cpu_gnt === 1'b1, 32'(cpu_gnt), 32'(1));
            check("run write we", mem_we === 1'b1, 32'(mem_we), 32'(1));
            check("run write addr", mem_addr === a, 32'(mem_addr), 32'(a));
            tick();
            exp_mem[a] = d;
            cpu_we = 0; rx_valid = 0; #1;
            check("run read gnt", cpu_gnt === 1'b1, 32'(cpu_gnt), 32'(1));
            check("run read we", mem_we === 1'b0, 32'(mem_we), 32'(0));
            check("run read data", cpu_rdata === d, 32'(cpu_rdata), 32'(d));
            tick();
        end
        cpu_req = 0; #1;
        check("run idle gnt", cpu_gnt === 1'b0, 32'(cpu_gnt), 32'(0));
        check_mem("run");

        bq = {8'h35, 8'hF1}; gq = {2, 10};
        load_session("basic", bq, gq, 0);
        bq = {8'h12, 8'h34}; gq = {1, 0};
        load_session("overrun", bq, gq, 0);
        bq = {}; gq = {};
        for (int i = 0; i < 18; i++) begin
            bq.push_back({4'(i % 16), 4'($urandom)});
            gq.push_back($urandom_range(1, 2));
        end
        load_session("saturate", bq, gq, 0);
        bq = {8'h7C}; gq = {3};
        load_session("fall_with_byte", bq, gq, 1);
        for (int r = 0; r < 4; r++) begin
            int nb;
            bq = {}; gq = {};
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                bq.push_back(8'($urandom));
                gq.push_back($urandom_range(0, 3));
            end
            load_session($sformatf("random%0d", r), bq, gq, 1'($urandom));
        end

        // Reset while a byte is pending: nothing written, no restart pulse.
        p_prog = 1; tick(); tick();
        rx_valid = 1; rx_data = 8'($urandom); tick();
        rx_valid = 0; rst_n = 0; p_prog = 0; #1;
        check("midreset we", mem_we === 1'b0, 32'(mem_we), 32'(0));
        tick();
        check("midreset halt", cpu_halt === 1'b0, 32'(cpu_halt), 32'(0));
        check("midreset busy", load_busy === 1'b0, 32'(load_busy), 32'(0));
        check("midreset restart", cpu_restart === 1'b0, 32'(cpu_restart), 32'(0));
        check("midreset count", load_count === 5'd0, 32'(load_count), 32'(0));
        check("midreset err", load_err === 1'b0, 32'(load_err), 32'(0));
        check("midreset we after", mem_we === 1'b0, 32'(mem_we), 32'(0));
        rst_n = 1; tick();
        check("midreset no pulse", cpu_restart === 1'b0, 32'(cpu_restart), 32'(0));
        check("midreset run halt", cpu_halt === 1'b0, 32'(cpu_halt), 32'(0));
        check_mem("midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
